// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream load channel for ram_loader.
//   ld_start : one-cycle request to begin a load (master -> loader)
//   ld_valid : byte available on ld_data       (master -> loader)
//   ld_data  : byte to be written into RAM      (master -> loader)
//   ld_ready : loader accepts a byte this cycle (loader -> master)
// A byte transfers on a posedge where ld_valid & ld_ready are both high.
interface ram_loader_if;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;

  modport master (output ld_start, output ld_valid, output ld_data, input ld_ready);
  modport slave  (input ld_start, input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/ram_loader.sv
// ram_loader: streams NWORDS bytes into the computer RAM over the shared bus
// while the CPU is halted, arbitrating the RAM controls between CPU and loader.
//
// Ports:
//   clk                   single system clock, all state on posedge
//   rst                   synchronous, active-low reset
//   bus[7:0]              shared computer bus (loader drives in ADDR/DATA/VADDR)
//   cpu_mi/cpu_ro/cpu_ri  CPU RAM control requests (passed through when idle)
//   cpu_halt              CPU halted; loader owns the RAM only while high
//   mi/ro/ri              arbitrated RAM controls (MAR load, RAM out, RAM write)
//   ld                    byte-stream load channel (ram_loader_if.slave)
//   busy/done/abort       loader status
//   err                   sticky readback mismatch (verify build only)
//
// Build option: define RAM_LOADER_VERIFY_EN to read every word back after
// writing it (adds VADDR/VREAD states and the err port).
module ram_loader #(
  parameter int unsigned NWORDS = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [7:0]    bus,
  input  logic          cpu_mi,
  input  logic          cpu_ro,
  input  logic          cpu_ri,
  input  logic          cpu_halt,
  output logic          mi,
  output logic          ro,
  output logic          ri,
  ram_loader_if.slave   ld,
  output logic          busy,
  output logic          done,
  output logic          abort
`ifdef RAM_LOADER_VERIFY_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADDR,
    S_DATA,
`ifdef RAM_LOADER_VERIFY_EN
    S_VADDR,
    S_VREAD,
`endif
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              word_end;

  logic              own;
  logic              mi_l, ro_l, ri_l;
  logic              bus_oe;
  logic [7:0]        bus_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    abort_d  = 1'b0;
    err_d    = err_q;
    word_end = 1'b0;

    // Losing the halt takes priority over everything, including a handshake
    // in the same cycle (ld_ready is already low, so the byte is dropped).
    if (state_q != S_IDLE && !cpu_halt) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ld.ld_start && cpu_halt) begin
            state_d = S_LOAD;
            addr_d  = '0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (ld.ld_valid) begin
            data_d  = ld.ld_data;
            state_d = S_ADDR;
          end
        end
        S_ADDR: state_d = S_DATA;
        S_DATA: begin
`ifdef RAM_LOADER_VERIFY_EN
          state_d = S_VADDR;
`else
          word_end = 1'b1;
`endif
        end
`ifdef RAM_LOADER_VERIFY_EN
        S_VADDR: state_d = S_VREAD;
        S_VREAD: begin
          if (bus != data_q) err_d = 1'b1;
          word_end = 1'b1;
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      if (word_end) begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
    end
  end

  // Loader-side controls are qualified by cpu_halt so the RAM is released
  // combinationally the moment the halt drops, ahead of the abort edge.
  always_comb begin
    busy    = rst && (state_q != S_IDLE);
    own     = busy && cpu_halt;
    mi_l    = 1'b0;
    ro_l    = 1'b0;
    ri_l    = 1'b0;
    bus_oe  = 1'b0;
    bus_out = 8'(addr_q);
    unique case (state_q)
      S_ADDR: begin
        mi_l   = 1'b1;
        bus_oe = 1'b1;
      end
      S_DATA: begin
        ri_l    = 1'b1;
        bus_oe  = 1'b1;
        bus_out = data_q;
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_VADDR: begin
        mi_l   = 1'b1;
        bus_oe = 1'b1;
      end
      S_VREAD: ro_l = 1'b1;
`endif
      default: ;
    endcase

    if (!rst) begin
      mi = 1'b0;
      ro = 1'b0;
      ri = 1'b0;
    end else if (busy) begin
      mi = own && mi_l;
      ro = own && ro_l;
      ri = own && ri_l;
    end else begin
      mi = cpu_mi;
      ro = cpu_ro;
      ri = cpu_ri;
    end

    ld.ld_ready = own && (state_q == S_LOAD);
    done        = own && (state_q == S_DONE);
    abort       = rst && abort_q;
  end

  assign bus = (own && bus_oe) ? bus_out : 'z;

`ifdef RAM_LOADER_VERIFY_EN
  assign err = rst && err_q;
`endif

endmodule
